// File: rtl/ram2_countdown_scanner.sv
// ram2_countdown_scanner
//
// On every minute tick this block sweeps the 16-entry RAM2 schedule table
// through the memory's second port. Each entry is {time_remaining[7:4],
// med_id[3:0]}. Every non-zero time_remaining is decremented and written
// back. When an entry goes from 1 to 0, a due-medication request is
// raised. The sweep stalls until the alarm logic acknowledges the request.
//
// Ports:
//   Clk, Rst        rising-edge clock, asynchronous active-low reset
//   Tick            one-cycle minute pulse that starts a sweep
//   Read_Address    RAM2 read address; changes only on entry to RD
//   Read_Data       RAM2 read data, valid in the cycle after RD
//   Write_Enable    one-cycle write strobe, asserted in WR for active entries
//   Write_Address   RAM2 write address
//   Write_Data      {new time_remaining, med_id}
//   Due_Valid       due-medication request, held until Due_Ack
//   Due_MedID       med_id of the due entry
//   Due_Ack         acknowledge from the alarm logic
//   Busy            sweep in progress
//   Overrun         one-cycle pulse when a tick is dropped
module ram2_countdown_scanner #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  output logic [3:0] Read_Address,
  input  logic [7:0] Read_Data,
  output logic       Write_Enable,
  output logic [3:0] Write_Address,
  output logic [7:0] Write_Data,
  output logic       Due_Valid,
  output logic [3:0] Due_MedID,
  input  logic       Due_Ack,
  output logic       Busy,
  output logic       Overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_DATA,
    S_WR,
    S_ACK
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       pend_q, pend_d;

  logic [3:0] rd_addr_q, rd_addr_d;
  logic       wr_en_q, wr_en_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       due_valid_q, due_valid_d;
  logic [3:0] due_medid_q, due_medid_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;

  logic [3:0] tr;
  logic [3:0] med_id;
  logic       entry_done;

  assign tr     = Read_Data[7:4];
  assign med_id = Read_Data[3:0];

  // State register and all output flops.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      due_valid_q <= 1'b0;
      due_medid_q <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      due_valid_q <= due_valid_d;
      due_medid_q <= due_medid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: sequencing, entry index and the pending-tick flag.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    entry_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Tick || pend_q) begin
          idx_d   = '0;
          pend_d  = 1'b0;
          state_d = S_RD;
        end
      end
      S_RD:   state_d = S_DATA;
      S_DATA: state_d = S_WR;
      S_WR: begin
        // A request raised this cycle but not yet acknowledged stalls the sweep.
        if (due_valid_q && !Due_Ack) state_d = S_ACK;
        else                         entry_done = 1'b1;
      end
      S_ACK:   if (Due_Ack) entry_done = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (entry_done) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = S_RD;
      end
    end

    // Ticks arriving mid-sweep (including the final cycle) are remembered once.
    if (Tick && (state_q != S_IDLE)) pend_d = 1'b1;
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    rd_addr_d   = rd_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    due_valid_d = due_valid_q;
    due_medid_d = due_medid_q;
    busy_d      = (state_d != S_IDLE);
    overrun_d   = Tick && (state_q != S_IDLE) && pend_q;

    if ((state_d == S_RD) && (state_q != S_RD)) rd_addr_d = idx_d;

    if (state_q == S_DATA) begin
      // A zero time_remaining is inactive or already due: never decremented.
      wr_en_d   = (tr != 4'd0);
      wr_addr_d = idx_q;
      wr_data_d = {(tr != 4'd0) ? (tr - 4'd1) : tr, med_id};
      if (tr == 4'd1) begin
        due_valid_d = 1'b1;
        due_medid_d = med_id;
      end
    end

    if (due_valid_q && Due_Ack && ((state_q == S_WR) || (state_q == S_ACK))) begin
      due_valid_d = 1'b0;
    end
  end

  assign Read_Address  = rd_addr_q;
  assign Write_Enable  = wr_en_q;
  assign Write_Address = wr_addr_q;
  assign Write_Data    = wr_data_q;
  assign Due_Valid     = due_valid_q;
  assign Due_MedID     = due_medid_q;
  assign Busy          = busy_q;
  assign Overrun       = overrun_q;

endmodule

// File: tb/tb_ram2_countdown_scanner.sv
module tb_ram2_countdown_scanner;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tick;
  logic [3:0] Read_Address;
  logic [7:0] Read_Data;
  logic       Write_Enable;
  logic [3:0] Write_Address;
  logic [7:0] Write_Data;
  logic       Due_Valid;
  logic [3:0] Due_MedID;
  logic       Due_Ack;
  logic       Busy;
  logic       Overrun;

  ram2_countdown_scanner #(.NUM_ENTRIES(16)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Tick         (Tick),
    .Read_Address (Read_Address),
    .Read_Data    (Read_Data),
    .Write_Enable (Write_Enable),
    .Write_Address(Write_Address),
    .Write_Data   (Write_Data),
    .Due_Valid    (Due_Valid),
    .Due_MedID    (Due_MedID),
    .Due_Ack      (Due_Ack),
    .Busy         (Busy),
    .Overrun      (Overrun)
  );

  always #5 Clk = ~Clk;

  // RAM2 second port: synchronous read, registered address.
  logic [7:0] mem [16];
  always @(posedge Clk) begin
    Read_Data <= mem[Read_Address];
    if (Write_Enable) mem[Write_Address] <= Write_Data;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    int         off;
  } wr_rec_t;

  wr_rec_t    wr_q[$];
  logic [3:0] due_q[$];
  int sweeps, busy_cycles, we_wide, medid_unstable, ovr_cnt, dv_cycles, start_cyc;
  logic busy_prev = 1'b0, we_prev = 1'b0, dv_prev = 1'b0;
  logic [3:0] medid_prev = '0;

  always @(negedge Clk) begin
    if (Rst) begin
      if (Busy && !busy_prev) begin
        sweeps++;
        start_cyc = cyc;
      end
      if (Busy) busy_cycles++;
      if (Write_Enable) begin
        wr_q.push_back('{Write_Address, Write_Data, cyc - start_cyc});
        if (we_prev) we_wide++;
      end
      if (Due_Valid) dv_cycles++;
      if (Due_Valid && !dv_prev) due_q.push_back(Due_MedID);
      if (Due_Valid && dv_prev && (Due_MedID != medid_prev)) medid_unstable++;
      if (Overrun) ovr_cnt++;
    end
    busy_prev  = Busy;
    we_prev    = Write_Enable;
    dv_prev    = Due_Valid;
    medid_prev = Due_MedID;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    due_q.delete();
    sweeps = 0; busy_cycles = 0; we_wide = 0; medid_unstable = 0;
    ovr_cnt = 0; dv_cycles = 0; start_cyc = 0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic tick_pulse();
    @(posedge Clk); #1 Tick = 1'b1;
    @(posedge Clk); #1 Tick = 1'b0;
  endtask

  // Start a sweep and wait (bounded) for it to finish.
  task automatic run_sweep(input bit rand_ack, input int budget);
    int n;
    tick_pulse();
    n = 0;
    while (Busy && n < budget) begin
      if (rand_ack) Due_Ack = 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
      n++;
    end
    Due_Ack = 1'b1;
    check("sweep_ends", {31'd0, Busy}, 32'd0);
  endtask

  // Reference rule for one entry: decrement a non-zero time field, keep id.
  function automatic logic [7:0] model_entry(input logic [7:0] e);
    int t;
    t = int'(e) / 16;
    if (t > 0) t = t - 1;
    return 8'(t * 16 + int'(e) % 16);
  endfunction

  typedef struct {
    int         addr;
    logic [7:0] init;
    logic [7:0] exp_final;
    int         exp_writes;
    int         exp_dues;
    int         exp_off;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int stall_ok;
    int others;
    logic [7:0] init_img [16];
    logic [7:0] exp_img  [16];
    logic [3:0] exp_due[$];
    int exp_writes;

    // Write offset for entry k is 3k+2 cycles after RD of entry 0.
    vecs[0] = '{5,  8'h35, 8'h25, 1, 0, 17};
    vecs[1] = '{9,  8'h19, 8'h09, 1, 1, 29};
    vecs[2] = '{0,  8'h1A, 8'h0A, 1, 1, 2};
    vecs[3] = '{15, 8'hF7, 8'hE7, 1, 0, 47};
    vecs[4] = '{3,  8'h0C, 8'h0C, 0, 0, 0};
    vecs[5] = '{12, 8'h00, 8'h00, 0, 0, 0};

    Rst = 1'b0; Tick = 1'b0; Due_Ack = 1'b1;
    clear_mem();
    clear_mon();
    repeat (3) @(posedge Clk);
    #1;
    check("reset_outputs",
          {13'd0, Read_Address, Write_Enable, Write_Address, Write_Data,
           Due_Valid, Due_MedID, Busy, Overrun}, 32'd0);
    Rst = 1'b1;

    // All-zero table: no writes, no dues, 48 busy cycles.
    clear_mon();
    run_sweep(1'b0, 200);
    check("zero_busy_len", busy_cycles, 48);
    check("zero_writes", wr_q.size(), 0);
    check("zero_dues", due_q.size(), 0);

    // Single-entry table vectors with Due_Ack tied high.
    foreach (vecs[v]) begin
      clear_mem();
      mem[vecs[v].addr] = vecs[v].init;
      clear_mon();
      run_sweep(1'b0, 200);
      check($sformatf("v%0d_final", v), mem[vecs[v].addr], vecs[v].exp_final);
      check($sformatf("v%0d_writes", v), wr_q.size(), vecs[v].exp_writes);
      check($sformatf("v%0d_dues", v), due_q.size(), vecs[v].exp_dues);
      check($sformatf("v%0d_busy", v), busy_cycles, 48);
      if (vecs[v].exp_writes == 1 && wr_q.size() == 1) begin
        check($sformatf("v%0d_waddr", v), wr_q[0].addr, vecs[v].addr);
        check($sformatf("v%0d_wdata", v), wr_q[0].data, vecs[v].exp_final);
        check($sformatf("v%0d_woff", v), wr_q[0].off, vecs[v].exp_off);
      end
      if (vecs[v].exp_dues == 1 && due_q.size() == 1)
        check($sformatf("v%0d_due_id", v), due_q[0], vecs[v].init[3:0]);
      others = 0;
      for (int i = 0; i < 16; i++) if (i != vecs[v].addr && mem[i] != 8'h00) others++;
      check($sformatf("v%0d_others", v), others, 0);
    end

    // Two adjacent dues with Due_Ack high: two single-cycle pulses.
    clear_mem();
    mem[2] = 8'h12; mem[3] = 8'h13;
    clear_mon();
    run_sweep(1'b0, 200);
    check("pair_dues", due_q.size(), 2);
    if (due_q.size() == 2) begin
      check("pair_id0", due_q[0], 4'd2);
      check("pair_id1", due_q[1], 4'd3);
    end
    check("pair_dv_cycles", dv_cycles, 2);
    check("pair_busy", busy_cycles, 48);
    check("pair_mem", {mem[2], mem[3]}, 16'h0203);

    // Stalled handshake on entry 9.
    clear_mem();
    mem[9] = 8'h19;
    clear_mon();
    Due_Ack = 1'b0;
    tick_pulse();
    n = 0;
    while (!Due_Valid && n < 200) begin @(posedge Clk); #1; n++; end
    check("stall_due_rise", Due_Valid, 1'b1);
    check("stall_medid", Due_MedID, 4'd9);
    check("stall_write", {Write_Enable, Write_Address, Write_Data}, {1'b1, 4'd9, 8'h09});
    stall_ok = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (Busy && Due_Valid && Due_MedID == 4'd9 && Read_Address == 4'd9 && !Write_Enable)
        stall_ok++;
    end
    check("stall_hold", stall_ok, 10);
    Due_Ack = 1'b1;
    @(posedge Clk); #1;
    check("stall_release", {Due_Valid, Busy, Read_Address}, {1'b0, 1'b1, 4'd10});
    n = 0;
    while (Busy && n < 200) begin @(posedge Clk); #1; n++; end
    check("stall_busy", busy_cycles, 58);
    check("stall_mem", mem[9], 8'h09);

    // Two ticks during a stall: one Overrun, exactly one extra sweep.
    clear_mem();
    mem[4] = 8'h14;
    clear_mon();
    Due_Ack = 1'b0;
    tick_pulse();
    n = 0;
    while (!Due_Valid && n < 200) begin @(posedge Clk); #1; n++; end
    check("ovr_due", Due_Valid, 1'b1);
    tick_pulse();
    check("ovr_first_tick", Overrun, 1'b0);
    tick_pulse();
    check("ovr_pulse", Overrun, 1'b1);
    @(posedge Clk); #1;
    check("ovr_pulse_end", Overrun, 1'b0);
    Due_Ack = 1'b1;
    repeat (150) @(posedge Clk);
    #1;
    check("ovr_sweeps", sweeps, 2);
    check("ovr_count", ovr_cnt, 1);
    check("ovr_idle", Busy, 1'b0);
    check("ovr_mem", mem[4], 8'h04);
    check("ovr_dues", due_q.size(), 1);

    // Reset in the middle of a sweep.
    for (int i = 0; i < 16; i++) mem[i] = {4'd5, 4'(i)};
    clear_mon();
    tick_pulse();
    n = 0;
    while (!(Busy && Read_Address == 4'd7) && n < 200) begin @(posedge Clk); #1; n++; end
    check("rst_reach_idx7", Read_Address, 4'd7);
    #1 Rst = 1'b0;
    #1;
    check("rst_outputs",
          {13'd0, Read_Address, Write_Enable, Write_Address, Write_Data,
           Due_Valid, Due_MedID, Busy, Overrun}, 32'd0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    others = 0;
    for (int i = 0; i < 16; i++)
      if (mem[i] != ((i < 7) ? {4'd4, 4'(i)} : {4'd5, 4'(i)})) others++;
    check("rst_partial_mem", others, 0);
    clear_mon();
    run_sweep(1'b0, 200);
    check("rst_restart_first", (wr_q.size() > 0) ? {28'd0, wr_q[0].addr} : 32'hFFFF, 32'd0);
    check("rst_restart_writes", wr_q.size(), 16);
    others = 0;
    for (int i = 0; i < 16; i++)
      if (mem[i] != ((i < 7) ? {4'd3, 4'(i)} : {4'd4, 4'(i)})) others++;
    check("rst_restart_mem", others, 0);

    // Randomised tables with random acknowledge timing.
    for (int it = 0; it < 20; it++) begin
      exp_due.delete();
      exp_writes = 0;
      for (int i = 0; i < 16; i++) begin
        init_img[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 2)), 4'($urandom)};
        mem[i] = init_img[i];
        exp_img[i] = model_entry(init_img[i]);
        if (init_img[i][7:4] != 4'd0) exp_writes++;
        if (init_img[i][7:4] == 4'd1) exp_due.push_back(init_img[i][3:0]);
      end
      clear_mon();
      run_sweep(1'b1, 3000);
      for (int i = 0; i < 16; i++)
        check($sformatf("rnd%0d_mem%0d", it, i), mem[i], exp_img[i]);
      check($sformatf("rnd%0d_writes", it), wr_q.size(), exp_writes);
      check($sformatf("rnd%0d_ndue", it), due_q.size(), exp_due.size());
      for (int k = 0; k < exp_due.size() && k < due_q.size(); k++)
        check($sformatf("rnd%0d_due%0d", it, k), due_q[k], exp_due[k]);
      check($sformatf("rnd%0d_sweeps", it), sweeps, 1);
    end

    check("we_single_cycle", we_wide, 0);
    check("medid_stable", medid_unstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
